// File: rtl/microwave_pkg.sv
// Shared state encodings and BCD constants for the microwave cooking-cycle sequencer.
package microwave_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ENTRY   = 3'd1;
    localparam logic [2:0] COOKING = 3'd2;
    localparam logic [2:0] PAUSED  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam int unsigned DigitW = 4;

    localparam logic [DigitW-1:0] MaxDigit   = 4'd9;
    localparam logic [DigitW-1:0] MaxSecTens = 4'd5;

    typedef logic [DigitW-1:0] bcd_t;

    typedef enum logic [2:0] {
        StIdle    = IDLE,
        StEntry   = ENTRY,
        StCooking = COOKING,
        StPaused  = PAUSED,
        StDone    = DONE
    } state_e;

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit MM:SS BCD register with clear, keypad shift-in and countdown decrement.
module bcd_mmss_counter
    import microwave_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic shift_i,
    input  logic dec_i,
    input  bcd_t digit_i,
    output bcd_t min_tens_o,
    output bcd_t min_ones_o,
    output bcd_t sec_tens_o,
    output bcd_t sec_ones_o,
    output logic zero_o,
    output logic next_zero_o
);

    bcd_t min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    bcd_t min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;

    assign zero_o      = (min_tens_q == '0) && (min_ones_q == '0) &&
                         (sec_tens_q == '0) && (sec_ones_q == '0);
    assign next_zero_o = (min_tens_q == '0) && (min_ones_q == '0) &&
                         (sec_tens_q == '0) && (sec_ones_q == 4'd1);

    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        if (clear_i) begin
            min_tens_d = '0;
            min_ones_d = '0;
            sec_tens_d = '0;
            sec_ones_d = '0;
        end else if (shift_i) begin
            min_tens_d = min_ones_q;
            min_ones_d = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = digit_i;
        end else if (dec_i && !zero_o) begin
            // Borrow chain; seconds wrap 00 -> 59, entered 60..99 still count down digit-wise.
            if (sec_ones_q != '0) begin
                sec_ones_d = sec_ones_q - 4'd1;
            end else begin
                sec_ones_d = MaxDigit;
                if (sec_tens_q != '0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                end else begin
                    sec_tens_d = MaxSecTens;
                    if (min_ones_q != '0) begin
                        min_ones_d = min_ones_q - 4'd1;
                    end else begin
                        min_ones_d = MaxDigit;
                        min_tens_d = min_tens_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
        end else begin
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
        end
    end

    assign min_tens_o = min_tens_q;
    assign min_ones_o = min_ones_q;
    assign sec_tens_o = sec_tens_q;
    assign sec_ones_o = sec_ones_q;

endmodule

// File: rtl/microwave_controller.sv
// Cooking-cycle sequencer: input edge detection, IDLE/ENTRY/COOKING/PAUSED/DONE FSM, done timer.
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int unsigned DONE_SECONDS = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       loadn,
    input  logic [3:0] D,
    input  logic       pgt_1Hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       mag_on,
    output logic       done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state
);

    state_e     state_q, state_d;
    logic [3:0] done_cnt_q, done_cnt_d;
    logic       loadn_q, pgt_q, startn_q, stopn_q;
    logic       mag_on_q, done_q;

    logic digit_ev, tick_ev, start_ev, stop_ev;
    logic clr, shift, dec, zero, next_zero;

    // Out-of-range key codes never count as a digit event.
    assign digit_ev = loadn_q & ~loadn & (D <= MaxDigit);
    assign tick_ev  = ~pgt_q & pgt_1Hz;
    assign start_ev = startn_q & ~startn;
    assign stop_ev  = stopn_q & ~stopn;

    always_comb begin
        state_d    = state_q;
        done_cnt_d = done_cnt_q;
        clr        = 1'b0;
        shift      = 1'b0;
        dec        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (digit_ev) begin
                    shift   = 1'b1;
                    state_d = StEntry;
                end
            end
            StEntry: begin
                if (stop_ev) begin
                    clr     = 1'b1;
                    state_d = StIdle;
                end else begin
                    shift = digit_ev;
                    if (start_ev && door_closed && !zero) state_d = StCooking;
                end
            end
            StCooking: begin
                if (stop_ev || !door_closed) begin
                    state_d = StPaused;
                end else if (tick_ev) begin
                    dec = 1'b1;
                    if (next_zero) begin
                        state_d    = StDone;
                        done_cnt_d = '0;
                    end
                end
            end
            StPaused: begin
                if (stop_ev) begin
                    clr     = 1'b1;
                    state_d = StIdle;
                end else if (start_ev && door_closed) begin
                    state_d = StCooking;
                end
            end
            StDone: begin
                if (stop_ev) begin
                    state_d    = StIdle;
                    done_cnt_d = '0;
                end else if (tick_ev) begin
                    if (done_cnt_q == 4'(DONE_SECONDS - 1)) begin
                        state_d    = StIdle;
                        done_cnt_d = '0;
                    end else begin
                        done_cnt_d = done_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Previous-value registers reset to the inactive level so reset release is event-free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            done_cnt_q <= '0;
            loadn_q    <= 1'b1;
            pgt_q      <= 1'b1;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
            mag_on_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_cnt_q <= done_cnt_d;
            loadn_q    <= loadn;
            pgt_q      <= pgt_1Hz;
            startn_q   <= startn;
            stopn_q    <= stopn;
            mag_on_q   <= (state_d == StCooking);
            done_q     <= (state_d == StDone);
        end
    end

    bcd_mmss_counter u_counter (
        .clk_i       (clk),
        .rst_ni      (resetn),
        .clear_i     (clr),
        .shift_i     (shift),
        .dec_i       (dec),
        .digit_i     (D),
        .min_tens_o  (min_tens),
        .min_ones_o  (min_ones),
        .sec_tens_o  (sec_tens),
        .sec_ones_o  (sec_ones),
        .zero_o      (zero),
        .next_zero_o (next_zero)
    );

    assign mag_on = mag_on_q;
    assign done   = done_q;
    assign state  = state_q;

endmodule

// File: tb/tb_microwave_controller.sv
// Scoreboard bench for microwave_controller: expectations queued per stimulus, popped after the edge.
module tb_microwave_controller;

    logic       clk, resetn, loadn, pgt_1Hz, startn, stopn, door_closed;
    logic [3:0] d_key;
    logic       mag_on, done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       mag;
        logic       dn;
        logic [15:0] disp;
    } exp_t;

    exp_t sb_q[$];

    microwave_controller #(
        .DONE_SECONDS (3)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .loadn       (loadn),
        .D           (d_key),
        .pgt_1Hz     (pgt_1Hz),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .mag_on      (mag_on),
        .done        (done),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [2:0] st, input logic mag,
                           input logic dn, input logic [15:0] disp);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.mag  = mag;
        e.dn   = dn;
        e.disp = disp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check_eq({e.tag, ".state"}, 32'(state), 32'(e.st));
            check_eq({e.tag, ".mag_on"}, 32'(mag_on), 32'(e.mag));
            check_eq({e.tag, ".done"}, 32'(done), 32'(e.dn));
            check_eq({e.tag, ".disp"}, 32'({min_tens, min_ones, sec_tens, sec_ones}),
                     32'(e.disp));
        end
    endtask

    task automatic press_key(input logic [3:0] d);
        @(negedge clk);
        d_key = d;
        loadn = 1'b0;
        @(negedge clk);
        loadn = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        pgt_1Hz = 1'b1;
        @(negedge clk);
        pgt_1Hz = 1'b0;
    endtask

    task automatic press(input logic do_start, input logic do_stop, input logic do_tick);
        @(negedge clk);
        startn  = ~do_start;
        stopn   = ~do_stop;
        pgt_1Hz = do_tick;
        @(negedge clk);
        startn  = 1'b1;
        stopn   = 1'b1;
        pgt_1Hz = 1'b0;
    endtask

    task automatic set_door(input logic closed);
        @(negedge clk);
        door_closed = closed;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        loadn = 1'b1;
        startn = 1'b1;
        stopn = 1'b1;
        pgt_1Hz = 1'b0;
        door_closed = 1'b1;
        d_key = 4'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        sb_push("reset", 3'd0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        sb_check();

        // 01:30 entry and countdown through the 01:00 -> 00:59 wrap
        sb_push("key1", 3'd1, 0, 0, 16'h0001); press_key(4'd1); sb_check();
        sb_push("key3", 3'd1, 0, 0, 16'h0013); press_key(4'd3); sb_check();
        sb_push("key0", 3'd1, 0, 0, 16'h0130); press_key(4'd0); sb_check();
        sb_push("start_130", 3'd2, 1, 0, 16'h0130); press(1, 0, 0); sb_check();
        sb_push("tick_129", 3'd2, 1, 0, 16'h0129); tick(); sb_check();
        sb_push("tick30_059", 3'd2, 1, 0, 16'h0059);
        repeat (30) tick();
        sb_check();
        sb_push("stop_pause", 3'd3, 0, 0, 16'h0059); press(0, 1, 0); sb_check();
        sb_push("stop_clear", 3'd0, 0, 0, 16'h0000); press(0, 1, 0); sb_check();

        // 5 second cook into DONE, then DONE_SECONDS ticks back to IDLE
        sb_push("key5", 3'd1, 0, 0, 16'h0005); press_key(4'd5); sb_check();
        sb_push("start_5", 3'd2, 1, 0, 16'h0005); press(1, 0, 0); sb_check();
        repeat (3) tick();
        sb_push("tick4_001", 3'd2, 1, 0, 16'h0001); tick(); sb_check();
        sb_push("tick5_done", 3'd4, 0, 1, 16'h0000); tick(); sb_check();
        sb_push("done_t1", 3'd4, 0, 1, 16'h0000); tick(); sb_check();
        sb_push("done_start_ign", 3'd4, 0, 1, 16'h0000); press(1, 0, 0); sb_check();
        sb_push("done_t2", 3'd4, 0, 1, 16'h0000); tick(); sb_check();
        sb_push("done_t3_idle", 3'd0, 0, 0, 16'h0000); tick(); sb_check();

        // Door opened while cooking at 00:40
        press_key(4'd4);
        sb_push("key40", 3'd1, 0, 0, 16'h0040); press_key(4'd0); sb_check();
        sb_push("start_40", 3'd2, 1, 0, 16'h0040); press(1, 0, 0); sb_check();
        sb_push("door_open", 3'd3, 0, 0, 16'h0040); set_door(1'b0); sb_check();
        sb_push("paused_ticks", 3'd3, 0, 0, 16'h0040);
        repeat (5) tick();
        sb_check();
        sb_push("start_door_open", 3'd3, 0, 0, 16'h0040); press(1, 0, 0); sb_check();
        set_door(1'b1);
        sb_push("resume", 3'd2, 1, 0, 16'h0040); press(1, 0, 0); sb_check();
        sb_push("tick_039", 3'd2, 1, 0, 16'h0039); tick(); sb_check();
        sb_push("door_tick", 3'd3, 0, 0, 16'h0039);
        @(negedge clk);
        door_closed = 1'b0;
        pgt_1Hz = 1'b1;
        @(negedge clk);
        pgt_1Hz = 1'b0;
        sb_check();
        door_closed = 1'b1;
        press(0, 1, 0);

        // Negative cases
        sb_push("idle_start", 3'd0, 0, 0, 16'h0000); press(1, 0, 0); sb_check();
        sb_push("idle_keyA", 3'd0, 0, 0, 16'h0000); press_key(4'hA); sb_check();
        sb_push("key7", 3'd1, 0, 0, 16'h0007); press_key(4'd7); sb_check();
        door_closed = 1'b0;
        sb_push("entry_door_open", 3'd1, 0, 0, 16'h0007); press(1, 0, 0); sb_check();
        door_closed = 1'b1;
        sb_push("entry_keyF", 3'd1, 0, 0, 16'h0007); press_key(4'hF); sb_check();
        sb_push("entry_stop", 3'd0, 0, 0, 16'h0000); press(0, 1, 0); sb_check();
        for (int i = 1; i <= 4; i++) press_key(4'(i));
        sb_push("keys_12345", 3'd1, 0, 0, 16'h2345); press_key(4'd5); sb_check();
        sb_push("entry_stop_start", 3'd0, 0, 0, 16'h0000); press(1, 1, 0); sb_check();

        // Seconds above 59 count down digit-wise; stop beats a coincident tick
        press_key(4'd9);
        press_key(4'd0);
        sb_push("start_90", 3'd2, 1, 0, 16'h0090); press(1, 0, 0); sb_check();
        sb_push("tick_089", 3'd2, 1, 0, 16'h0089); tick(); sb_check();
        sb_push("stop_tick", 3'd3, 0, 0, 16'h0089); press(0, 1, 1); sb_check();
        sb_push("resume_89", 3'd2, 1, 0, 16'h0089); press(1, 0, 0); sb_check();
        sb_push("cook_stop_start", 3'd3, 0, 0, 16'h0089); press(1, 1, 0); sb_check();
        sb_push("paused_stop", 3'd0, 0, 0, 16'h0000); press(0, 1, 0); sb_check();

        // Asynchronous reset while cooking at 12:00
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd0);
        sb_push("key_1200", 3'd1, 0, 0, 16'h1200); press_key(4'd0); sb_check();
        sb_push("start_1200", 3'd2, 1, 0, 16'h1200); press(1, 0, 0); sb_check();
        @(negedge clk);
        #2;
        pgt_1Hz = 1'b1;
        resetn = 1'b0;
        #1;
        sb_push("async_reset", 3'd0, 0, 0, 16'h0000); sb_check();
        @(negedge clk);
        resetn = 1'b1;
        sb_push("post_reset_1", 3'd0, 0, 0, 16'h0000); @(negedge clk); sb_check();
        sb_push("post_reset_key", 3'd1, 0, 0, 16'h0008); press_key(4'd8); sb_check();
        pgt_1Hz = 1'b0;

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
